// File: rtl/shift_width_converter.sv
// Ready/valid width converter: serialises wide words (IWidth > OWidth) or accumulates narrow ones (OWidth > IWidth).
// Latency: one cycle from input accept to first output chunk / full word; full throughput, no bubbles between words.
// Backpressure: OutReady=0 holds OutData stable; InAccept drops until the held word/chunk set can drain. Checker macro: SHIFT_WIDTH_CONVERTER_CHECK_EN.
module shift_width_converter #(
    parameter int IWidth  = 32,
    parameter int OWidth  = 8,
    parameter bit Reverse = 1'b0
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [IWidth-1:0] InData,
    input  logic              InValid,
    output logic              InAccept,
    output logic [OWidth-1:0] OutData,
    output logic              OutValid,
    input  logic              OutReady
);

    localparam int Ratio = (IWidth > OWidth) ? IWidth / OWidth : OWidth / IWidth;
    localparam int CntW  = $clog2(Ratio + 1);

    logic inXfer;
    logic outXfer;

    assign inXfer  = InValid & InAccept;
    assign outXfer = OutValid & OutReady;

    generate
        if (IWidth > OWidth) begin : gDown
            logic [IWidth-1:0] holdReg;
            logic [CntW-1:0]   chunkCnt;
            logic [CntW-1:0]   selIdx;
            logic              full;
            logic              lastChunk;
            logic [OWidth-1:0] chunks [Ratio];

            for (genvar k = 0; k < Ratio; k++) begin : gChunk
                assign chunks[k] = holdReg[k*OWidth +: OWidth];
            end

            assign lastChunk = (chunkCnt == CntW'(Ratio - 1));
            assign selIdx    = Reverse ? (CntW'(Ratio - 1) - chunkCnt) : chunkCnt;
            assign InAccept  = ~full | (outXfer & lastChunk);
            assign OutValid  = full;
            assign OutData   = chunks[selIdx];

            // A load in the same cycle as the last chunk leaves full set: no bubble.
            always_ff @(posedge Clock or negedge Reset) begin
                if (!Reset) begin
                    holdReg  <= '0;
                    chunkCnt <= '0;
                    full     <= 1'b0;
                end else if (inXfer) begin
                    holdReg  <= InData;
                    chunkCnt <= '0;
                    full     <= 1'b1;
                end else if (outXfer) begin
                    if (lastChunk) begin
                        chunkCnt <= '0;
                        full     <= 1'b0;
                    end else begin
                        chunkCnt <= chunkCnt + 1'b1;
                    end
                end
            end
        end else if (OWidth > IWidth) begin : gUp
            logic [OWidth-1:0] accReg;
            logic [CntW-1:0]   fillCnt;
            logic [CntW-1:0]   baseFill;
            logic [CntW-1:0]   slotIdx;

            // An output transfer frees the whole accumulator, so a concurrent input becomes word 0.
            assign baseFill = outXfer ? '0 : fillCnt;
            assign slotIdx  = Reverse ? (CntW'(Ratio - 1) - baseFill) : baseFill;
            assign OutValid = (fillCnt == CntW'(Ratio));
            assign InAccept = (fillCnt < CntW'(Ratio)) | OutReady;
            assign OutData  = accReg;

            always_ff @(posedge Clock or negedge Reset) begin
                if (!Reset) begin
                    accReg  <= '0;
                    fillCnt <= '0;
                end else begin
                    for (int k = 0; k < Ratio; k++) begin
                        if (inXfer && (slotIdx == CntW'(k))) begin
                            accReg[k*IWidth +: IWidth] <= InData;
                        end
                    end
                    if (outXfer) begin
                        fillCnt <= inXfer ? CntW'(1) : '0;
                    end else if (inXfer) begin
                        fillCnt <= fillCnt + 1'b1;
                    end
                end
            end
        end else begin : gEqual
            logic [IWidth-1:0] dataReg;
            logic              vldReg;

            assign InAccept = ~vldReg | OutReady;
            assign OutValid = vldReg;
            assign OutData  = dataReg;

            always_ff @(posedge Clock or negedge Reset) begin
                if (!Reset) begin
                    dataReg <= '0;
                    vldReg  <= 1'b0;
                end else if (inXfer) begin
                    dataReg <= InData;
                    vldReg  <= 1'b1;
                end else if (outXfer) begin
                    vldReg  <= 1'b0;
                end
            end
        end
    endgenerate

`ifdef SHIFT_WIDTH_CONVERTER_CHECK_EN
    logic              prevValid;
    logic              prevAccept;
    logic [IWidth-1:0] prevData;

    initial begin
        if (((IWidth % OWidth) != 0) && ((OWidth % IWidth) != 0)) begin
            $display("ERROR %m: IWidth=%0d and OWidth=%0d are not integer multiples", IWidth, OWidth);
            $finish;
        end
    end

    // A stalled offer must be held: same data, valid kept high until accepted.
    always @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            prevValid  <= 1'b0;
            prevAccept <= 1'b1;
            prevData   <= '0;
        end else begin
            if (InValid && $isunknown(InData)) begin
                $display("WARNING %m: X/Z on InData while InValid at time %0t", $time);
            end
            if (prevValid && !prevAccept && (!InValid || (InData !== prevData))) begin
                $display("ERROR %m: input changed while stalled at time %0t", $time);
            end
            prevValid  <= InValid;
            prevAccept <= InAccept;
            prevData   <= InData;
        end
    end
`else
    // Checker not compiled in this build.
`endif

endmodule

// File: tb/tb_shift_width_converter.sv
// Self-checking bench: four converter instances (104->8 rev, 8->32, 8->32 rev, 32->8) against queue-based models.
module tb_shift_width_converter;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    always #5 Clock = ~Clock;

    int cmpCnt = 0;
    int errCnt = 0;

    logic [103:0] aIn;  logic aVld, aAcc, aOV, aRdy; logic [7:0]  aOut;
    logic [7:0]   bIn;  logic bVld, bAcc, bOV, bRdy; logic [31:0] bOut;
    logic [7:0]   cIn;  logic cVld, cAcc, cOV, cRdy; logic [31:0] cOut;
    logic [31:0]  dIn;  logic dVld, dAcc, dOV, dRdy; logic [7:0]  dOut;

    shift_width_converter #(.IWidth(104), .OWidth(8), .Reverse(1'b1)) dutA (
        .Clock(Clock), .Reset(Reset), .InData(aIn), .InValid(aVld), .InAccept(aAcc),
        .OutData(aOut), .OutValid(aOV), .OutReady(aRdy));
    shift_width_converter #(.IWidth(8), .OWidth(32), .Reverse(1'b0)) dutB (
        .Clock(Clock), .Reset(Reset), .InData(bIn), .InValid(bVld), .InAccept(bAcc),
        .OutData(bOut), .OutValid(bOV), .OutReady(bRdy));
    shift_width_converter #(.IWidth(8), .OWidth(32), .Reverse(1'b1)) dutC (
        .Clock(Clock), .Reset(Reset), .InData(cIn), .InValid(cVld), .InAccept(cAcc),
        .OutData(cOut), .OutValid(cOV), .OutReady(cRdy));
    shift_width_converter #(.IWidth(32), .OWidth(8), .Reverse(1'b0)) dutD (
        .Clock(Clock), .Reset(Reset), .InData(dIn), .InValid(dVld), .InAccept(dAcc),
        .OutData(dOut), .OutValid(dOV), .OutReady(dRdy));

    task automatic test_reset;
        @(negedge Clock); #1;
        cmpCnt++; if ({aOV, bOV, cOV, dOV} !== 4'b0000) begin errCnt++; $display("FAIL reset_outvalid got=%b want=0000", {aOV, bOV, cOV, dOV}); end
        Reset = 1'b1;
        @(negedge Clock); #1;
        cmpCnt++; if ({aAcc, bAcc, cAcc, dAcc} !== 4'b1111) begin errCnt++; $display("FAIL reset_inaccept got=%b want=1111", {aAcc, bAcc, cAcc, dAcc}); end
        cmpCnt++; if ({aOV, bOV, cOV, dOV} !== 4'b0000) begin errCnt++; $display("FAIL reset_idle_valid got=%b want=0000", {aOV, bOV, cOV, dOV}); end
    endtask

    task automatic test_down_reverse;
        logic [103:0] w;
        logic [103:0] sh;
        w = {8'h00, 32'h38c, 32'h0, 32'h0};
        @(negedge Clock); aIn = w; aVld = 1'b1; aRdy = 1'b1; #1;
        cmpCnt++; if (aAcc !== 1'b1) begin errCnt++; $display("FAIL a_load_accept got=%b want=1", aAcc); end
        @(negedge Clock); aVld = 1'b0;
        for (int i = 0; i < 13; i++) begin
            #1;
            sh = w >> (8 * (12 - i));
            cmpCnt++; if (aOV !== 1'b1 || aOut !== sh[7:0]) begin errCnt++; $display("FAIL a_byte%0d got=%b/%h want=1/%h", i, aOV, aOut, sh[7:0]); end
            if (i == 12) begin
                cmpCnt++; if (aAcc !== 1'b1) begin errCnt++; $display("FAIL a_last_accept got=%b want=1", aAcc); end
            end
            @(negedge Clock);
        end
        #1;
        cmpCnt++; if (aOV !== 1'b0) begin errCnt++; $display("FAIL a_empty got=%b want=0", aOV); end
    endtask

    task automatic test_upsize;
        logic [7:0] bytes [4];
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            @(negedge Clock); bIn = bytes[i]; cIn = bytes[i]; bVld = 1'b1; cVld = 1'b1; bRdy = 1'b0; cRdy = 1'b0; #1;
            cmpCnt++; if (bAcc !== 1'b1 || bOV !== 1'b0) begin errCnt++; $display("FAIL up_fill%0d acc/vld got=%b%b want=10", i, bAcc, bOV); end
        end
        @(negedge Clock); bVld = 1'b0; cVld = 1'b0; #1;
        cmpCnt++; if (bOV !== 1'b1 || bOut !== 32'h44332211) begin errCnt++; $display("FAIL up_word_fwd got=%b/%h want=1/44332211", bOV, bOut); end
        cmpCnt++; if (cOV !== 1'b1 || cOut !== 32'h11223344) begin errCnt++; $display("FAIL up_word_rev got=%b/%h want=1/11223344", cOV, cOut); end
        @(negedge Clock); #1;
        cmpCnt++; if (bOV !== 1'b1 || bOut !== 32'h44332211 || bAcc !== 1'b0) begin errCnt++; $display("FAIL up_hold got=%b/%h/%b want=1/44332211/0", bOV, bOut, bAcc); end
        @(negedge Clock); bIn = 8'h55; cIn = 8'h55; bVld = 1'b1; cVld = 1'b1; bRdy = 1'b1; cRdy = 1'b1; #1;
        cmpCnt++; if (bAcc !== 1'b1 || bOV !== 1'b1) begin errCnt++; $display("FAIL up_simul acc/vld got=%b%b want=11", bAcc, bOV); end
        bytes = '{8'h55, 8'h66, 8'h77, 8'h88};
        for (int i = 1; i < 4; i++) begin
            @(negedge Clock); bIn = bytes[i]; cIn = bytes[i]; bRdy = 1'b0; cRdy = 1'b0; #1;
            cmpCnt++; if (bOV !== 1'b0) begin errCnt++; $display("FAIL up_refill%0d got=%b want=0", i, bOV); end
        end
        @(negedge Clock); bVld = 1'b0; cVld = 1'b0; #1;
        cmpCnt++; if (bOV !== 1'b1 || bOut !== 32'h88776655) begin errCnt++; $display("FAIL up_next_fwd got=%b/%h want=1/88776655", bOV, bOut); end
        cmpCnt++; if (cOV !== 1'b1 || cOut !== 32'h55667788) begin errCnt++; $display("FAIL up_next_rev got=%b/%h want=1/55667788", cOV, cOut); end
        @(negedge Clock); bRdy = 1'b1; cRdy = 1'b1;
        @(negedge Clock); bRdy = 1'b0; cRdy = 1'b0; #1;
        cmpCnt++; if (bOV !== 1'b0 || cOV !== 1'b0) begin errCnt++; $display("FAIL up_drained got=%b%b want=00", bOV, cOV); end
    endtask

    task automatic test_down_backpressure;
        logic [31:0] w1;
        logic [31:0] w2;
        logic [31:0] sh;
        int idx;
        w1 = 32'hA1B2C3D4; w2 = 32'h55667788; idx = 0;
        @(negedge Clock); dIn = w1; dVld = 1'b1; dRdy = 1'b0; #1;
        cmpCnt++; if (dAcc !== 1'b1) begin errCnt++; $display("FAIL d_load_accept got=%b want=1", dAcc); end
        @(negedge Clock); dIn = w2;
        for (int k = 0; k < 12 && idx < 4; k++) begin
            dRdy = (k % 2 == 0); #1;
            sh = w1 >> (8 * idx);
            cmpCnt++; if (dOV !== 1'b1 || dOut !== sh[7:0]) begin errCnt++; $display("FAIL d_toggle_byte%0d got=%b/%h want=1/%h", idx, dOV, dOut, sh[7:0]); end
            cmpCnt++; if (dAcc !== (idx == 3 && dRdy)) begin errCnt++; $display("FAIL d_toggle_accept%0d got=%b want=%b", k, dAcc, (idx == 3 && dRdy)); end
            if (dRdy) idx++;
            @(negedge Clock);
        end
        cmpCnt++; if (idx != 4) begin errCnt++; $display("FAIL d_toggle_count got=%0d want=4", idx); end
        dVld = 1'b0; dRdy = 1'b1;
        for (int j = 0; j < 4; j++) begin
            #1; sh = w2 >> (8 * j);
            cmpCnt++; if (dOV !== 1'b1 || dOut !== sh[7:0]) begin errCnt++; $display("FAIL d_second_byte%0d got=%b/%h want=1/%h", j, dOV, dOut, sh[7:0]); end
            @(negedge Clock);
        end
        #1;
        cmpCnt++; if (dOV !== 1'b0) begin errCnt++; $display("FAIL d_empty got=%b want=0", dOV); end
    endtask

    task automatic test_back_to_back;
        logic [103:0] words [7];
        logic [103:0] sh;
        logic [31:0]  r0, r1, r2, r3;
        logic [7:0]   q [$];
        logic [7:0]   e;
        int wi, got, cyc;
        logic inX;
        for (int i = 0; i < 7; i++) begin
            r0 = $urandom; r1 = $urandom; r2 = $urandom; r3 = $urandom;
            words[i] = {r0[7:0], r1, r2, r3};
        end
        wi = 0; got = 0; cyc = 0;
        @(negedge Clock); aRdy = 1'b1; aVld = 1'b1; aIn = words[0];
        while (cyc < 300 && got < 91) begin
            #1;
            inX = aVld & aAcc;
            if (got > 0) begin
                cmpCnt++; if (aOV !== 1'b1) begin errCnt++; $display("FAIL stream_bubble cycle=%0d got=%b want=1", cyc, aOV); end
            end
            if (aOV === 1'b1) begin
                if (q.size() == 0) begin
                    errCnt++; cmpCnt++; $display("FAIL stream_extra got=%h want=none", aOut);
                end else begin
                    e = q.pop_front();
                    cmpCnt++; if (aOut !== e) begin errCnt++; $display("FAIL stream_byte%0d got=%h want=%h", got, aOut, e); end
                end
                got++;
            end
            if (inX) begin
                for (int j = 12; j >= 0; j--) begin sh = aIn >> (8 * j); q.push_back(sh[7:0]); end
                wi++;
            end
            cyc++;
            @(negedge Clock);
            aVld = (wi < 7);
            if (wi < 7) aIn = words[wi];
        end
        aVld = 1'b0;
        cmpCnt++; if (got != 91 || cyc != 92) begin errCnt++; $display("FAIL stream_count bytes=%0d cycles=%0d want=91/92", got, cyc); end
        cmpCnt++; if (q.size() != 0 || wi != 7) begin errCnt++; $display("FAIL stream_leftover queue=%0d words=%0d want=0/7", q.size(), wi); end
    endtask

    task automatic test_random;
        logic [7:0]  dq [$];
        logic [7:0]  bq [$];
        logic [7:0]  e, b0, b1, b2, b3;
        logic [31:0] sh;
        logic dInX, dOutX, bInX, bOutX;
        logic dStall, bStall;
        logic [7:0]  dHeld;
        logic [31:0] bHeld;
        dStall = 1'b0; bStall = 1'b0; dHeld = '0; bHeld = '0;
        dInX = 1'b0; bInX = 1'b0;
        @(negedge Clock); dVld = 1'b0; bVld = 1'b0;
        for (int cyc = 0; cyc < 420; cyc++) begin
            if (!(dVld && !dInX)) begin dVld = (cyc < 400) && ($urandom_range(0, 3) != 0); dIn = $urandom; end
            if (!(bVld && !bInX)) begin bVld = (cyc < 400) && ($urandom_range(0, 3) != 0); bIn = 8'($urandom_range(0, 255)); end
            dRdy = (cyc >= 400) || ($urandom_range(0, 2) != 0);
            bRdy = (cyc >= 400) || ($urandom_range(0, 2) != 0);
            #1;
            dInX = dVld & dAcc; dOutX = dOV & dRdy;
            bInX = bVld & bAcc; bOutX = bOV & bRdy;
            if (dStall) begin
                cmpCnt++; if (dOV !== 1'b1 || dOut !== dHeld) begin errCnt++; $display("FAIL rnd_d_hold got=%b/%h want=1/%h", dOV, dOut, dHeld); end
            end
            if (bStall) begin
                cmpCnt++; if (bOV !== 1'b1 || bOut !== bHeld) begin errCnt++; $display("FAIL rnd_b_hold got=%b/%h want=1/%h", bOV, bOut, bHeld); end
            end
            dStall = dOV & ~dRdy; dHeld = dOut;
            bStall = bOV & ~bRdy; bHeld = bOut;
            if (dOutX) begin
                cmpCnt++;
                if (dq.size() == 0) begin errCnt++; $display("FAIL rnd_d_extra got=%h want=none", dOut); end
                else begin e = dq.pop_front(); if (dOut !== e) begin errCnt++; $display("FAIL rnd_d_byte got=%h want=%h", dOut, e); end end
            end
            if (bOutX) begin
                cmpCnt++;
                if (bq.size() < 4) begin errCnt++; $display("FAIL rnd_b_early got=%h want=pending bytes=%0d", bOut, bq.size()); end
                else begin
                    b0 = bq.pop_front(); b1 = bq.pop_front(); b2 = bq.pop_front(); b3 = bq.pop_front();
                    if (bOut !== {b3, b2, b1, b0}) begin errCnt++; $display("FAIL rnd_b_word got=%h want=%h", bOut, {b3, b2, b1, b0}); end
                end
            end
            if (dInX) for (int j = 0; j < 4; j++) begin sh = dIn >> (8 * j); dq.push_back(sh[7:0]); end
            if (bInX) bq.push_back(bIn);
            @(negedge Clock);
        end
        dVld = 1'b0; bVld = 1'b0; dRdy = 1'b0; bRdy = 1'b0;
        cmpCnt++; if (dq.size() != 0) begin errCnt++; $display("FAIL rnd_d_drain got=%0d want=0", dq.size()); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] bytes [4];
        @(negedge Clock); dIn = 32'hCAFEF00D; dVld = 1'b1; dRdy = 1'b1; bIn = 8'h01; bVld = 1'b1; bRdy = 1'b0;
        @(negedge Clock); dVld = 1'b0; bIn = 8'h02;
        @(negedge Clock); bVld = 1'b0; #1;
        cmpCnt++; if (dOV !== 1'b1) begin errCnt++; $display("FAIL mid_pre_valid got=%b want=1", dOV); end
        Reset = 1'b0; #1;
        cmpCnt++; if (dOV !== 1'b0 || bOV !== 1'b0) begin errCnt++; $display("FAIL mid_reset_valid got=%b%b want=00", dOV, bOV); end
        @(negedge Clock); Reset = 1'b1; dRdy = 1'b0;
        bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        for (int i = 0; i < 4; i++) begin
            @(negedge Clock); bIn = bytes[i]; bVld = 1'b1; #1;
            cmpCnt++; if (bOV !== 1'b0) begin errCnt++; $display("FAIL mid_partial%0d got=%b want=0", i, bOV); end
        end
        @(negedge Clock); bVld = 1'b0; #1;
        cmpCnt++; if (bOV !== 1'b1 || bOut !== 32'hDDCCBBAA) begin errCnt++; $display("FAIL mid_word got=%b/%h want=1/ddccbbaa", bOV, bOut); end
        cmpCnt++; if (dOV !== 1'b0) begin errCnt++; $display("FAIL mid_down_discard got=%b want=0", dOV); end
        @(negedge Clock); bRdy = 1'b1;
        @(negedge Clock); bRdy = 1'b0; #1;
        cmpCnt++; if (bOV !== 1'b0) begin errCnt++; $display("FAIL mid_single_word got=%b want=0", bOV); end
    endtask

    initial begin
        aIn = '0; aVld = 1'b0; aRdy = 1'b0;
        bIn = '0; bVld = 1'b0; bRdy = 1'b0;
        cIn = '0; cVld = 1'b0; cRdy = 1'b0;
        dIn = '0; dVld = 1'b0; dRdy = 1'b0;
        Reset = 1'b0;
        repeat (2) @(negedge Clock);
        test_reset();
        test_down_reverse();
        test_upsize();
        test_down_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
        $finish;
    end

endmodule
